// File: rtl/stage_pkg.sv
// Shared types and constants for the stage lighting controller.
// State codes double as the externally visible mode_o value.
package stage_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_BLANK   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_MUSIC   = 3'd3,
    ST_SPEAKER = 3'd4,
    ST_HOUSE   = 3'd5
  } state_e;

  localparam int MSW_PLAY    = 0;
  localparam int MSW_MUSIC   = 1;
  localparam int MSW_SPEAKER = 2;
  localparam int MSW_HOUSE   = 3;

  function automatic int center_pos(input int n_pos);
    return n_pos / 2;
  endfunction

endpackage

// File: rtl/stage_spot_track.sv
// Debounced spotlight tracker: synchronises active-low presence sensors and moves
// the spotlight once a single sensor has been seen for HOLD_CYC consecutive cycles.
module stage_spot_track
  import stage_pkg::*;
#(
  parameter int N_POS    = 4,
  parameter int HOLD_CYC = 3,
  parameter int PW       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_POS-1:0] sens_n,
  output logic [PW-1:0]    spot_pos
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD    = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] H_ONE   = HW'(1);
  localparam logic [PW-1:0] CENTER  = PW'(center_pos(N_POS));

  logic [N_POS-1:0] sync1_q, sync2_q, s;
  logic             valid;
  logic [PW-1:0]    cand;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [PW-1:0]    cand_q, cand_d;
  logic [PW-1:0]    pos_q, pos_d;

  // Synchroniser idles high so a reset does not look like every sensor asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sens_n;
      sync2_q <= sync1_q;
    end
  end

  assign s     = ~sync2_q;
  assign valid = $onehot(s);

  always_comb begin
    cand = '0;
    for (int i = 0; i < N_POS; i++) begin
      if (s[i]) cand = PW'(i);
    end
  end

  always_comb begin
    hcnt_d = hcnt_q;
    cand_d = cand_q;
    pos_d  = pos_q;
    if (!en) begin
      hcnt_d = '0;
      pos_d  = CENTER;
    end else if (!valid) begin
      hcnt_d = '0;
    end else if (hcnt_q != '0 && cand == cand_q) begin
      // Saturated count means the move already happened for this sensor.
      if (hcnt_q != HOLD) begin
        hcnt_d = hcnt_q + H_ONE;
        if (hcnt_q == HOLD_M1) pos_d = cand;
      end
    end else begin
      cand_d = cand;
      hcnt_d = H_ONE;
      if (HOLD_CYC == 1) pos_d = cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      cand_q <= '0;
      pos_q  <= CENTER;
    end else begin
      hcnt_q <= hcnt_d;
      cand_q <= cand_d;
      pos_q  <= pos_d;
    end
  end

  assign spot_pos = pos_q;

endmodule

// File: rtl/stage_ctrl_n.sv
// Top-level stage lighting controller: request decode, blanked mode FSM and
// Moore output decode, with the spotlight tracker enabled in PLAY and SPEAKER.
module stage_ctrl_n
  import stage_pkg::*;
#(
  parameter int N_POS     = 4,
  parameter int HOLD_CYC  = 3,
  parameter int XFADE_CYC = 4,
  localparam int PW = ($clog2(N_POS) < 1) ? 1 : $clog2(N_POS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sys_en,
  input  logic [3:0]       mode_sw,
  input  logic [N_POS-1:0] sens_n,
  output logic             vis,
  output logic             house_lt,
  output logic             spot_on,
  output logic [PW-1:0]    spot_pos,
  output logic [2:0]       mode_o
);

  localparam int XW = (XFADE_CYC > 1) ? $clog2(XFADE_CYC) : 1;
  localparam logic [XW-1:0] XLOAD = XW'(XFADE_CYC - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);

  state_e        req;
  state_e        state_q, state_d;
  state_e        target_q, target_d;
  logic [XW-1:0] xcnt_q, xcnt_d;
  logic          track_en;

  always_comb begin
    req = ST_OFF;
    if (sys_en && $onehot(mode_sw)) begin
      if (mode_sw[MSW_PLAY])         req = ST_PLAY;
      else if (mode_sw[MSW_MUSIC])   req = ST_MUSIC;
      else if (mode_sw[MSW_SPEAKER]) req = ST_SPEAKER;
      else                           req = ST_HOUSE;
    end
  end

  // Dropping to OFF bypasses blanking so lights can always be killed at once.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    xcnt_d   = xcnt_q;
    if (req == ST_OFF) begin
      state_d = ST_OFF;
    end else if (state_q == ST_BLANK) begin
      if (req != target_q) begin
        target_d = req;
        xcnt_d   = XLOAD;
      end else if (xcnt_q != '0) begin
        xcnt_d = xcnt_q - X_ONE;
      end else begin
        state_d = target_q;
      end
    end else if (req != state_q) begin
      state_d  = ST_BLANK;
      target_d = req;
      xcnt_d   = XLOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      target_q <= ST_OFF;
      xcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      xcnt_q   <= xcnt_d;
    end
  end

  assign vis      = (state_q == ST_PLAY) || (state_q == ST_MUSIC);
  assign spot_on  = (state_q == ST_PLAY) || (state_q == ST_SPEAKER);
  assign house_lt = (state_q == ST_HOUSE);
  assign mode_o   = state_q;
  assign track_en = spot_on;

  stage_spot_track #(
    .N_POS    (N_POS),
    .HOLD_CYC (HOLD_CYC),
    .PW       (PW)
  ) u_spot (
    .clk      (clk),
    .rst      (rst),
    .en       (track_en),
    .sens_n   (sens_n),
    .spot_pos (spot_pos)
  );

endmodule

// File: doc/stage_ctrl_n.md
# stage_ctrl_n

Parametrised theater stage controller: one-hot mode switches select PLAY, MUSIC, SPEAKER or HOUSE behind a master enable. Every mode change passes through a timed blanking interval. In PLAY and SPEAKER, a debounced N-position spotlight tracker follows active-low presence sensors. It is the top-level lighting controller; its outputs drive the visualisation, house-light and spotlight drivers directly.

## Interface
- N_POS, 4: number of spotlight positions and sensors, at least 2. PW = max(1, $clog2(N_POS)).
- HOLD_CYC, 3: consecutive cycles a single sensor must be asserted before the spotlight moves, at least 1.
- XFADE_CYC, 4: length of the blanking interval in cycles, at least 1.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- sys_en  in  1  master enable.
- mode_sw  in  4  one-hot mode request: [0] PLAY, [1] MUSIC, [2] SPEAKER, [3] HOUSE.
- sens_n  in  N_POS  presence sensors, active low, asynchronous to clk.
- vis  out  1  visualisation on.
- house_lt  out  1  house lights on.
- spot_on  out  1  spotlight on.
- spot_pos  out  PW  spotlight position index.
- mode_o  out  3  current state code.

## Operation
- Request decode: req = the mode of the set mode_sw bit when sys_en = 1 and exactly one bit is set; otherwise req = OFF.
- States and mode_o codes: OFF = 0, BLANK = 1, PLAY = 2, MUSIC = 3, SPEAKER = 4, HOUSE = 5.
- Outputs by state:
  - PLAY: vis = 1, spot_on = 1.
  - MUSIC: vis = 1.
  - SPEAKER: spot_on = 1.
  - HOUSE: house_lt = 1.
  - OFF, BLANK: all outputs 0.
- Mode transitions:
  - req = OFF from any state: go to OFF at the next edge. No blanking; this is the safety path.
  - req ≠ OFF and req ≠ current state (current is OFF or a mode): enter BLANK, latch target = req, load xcnt = XFADE_CYC-1.
  - In BLANK with req = target and xcnt > 0: decrement xcnt.
  - In BLANK with req = target and xcnt = 0: go to target.
  - In BLANK with req ≠ target and req ≠ OFF: relatch target, reload xcnt = XFADE_CYC-1.
- Sensor input: sens_n passes through a 2-flop synchroniser, then is inverted to active-high s.
- Spotlight tracker, enabled only when state is PLAY or SPEAKER:
  - cand = index of the set bit of s when exactly one bit is set.
  - Same cand as last cycle: hcnt increments, saturating at HOLD_CYC.
  - New cand: hcnt = 1.
  - Zero or multiple bits set: hcnt = 0 and spot_pos holds.
  - Move: spot_pos is loaded with cand on the edge where hcnt would reach HOLD_CYC. It is loaded once; a saturated hcnt causes no further loads.
  - Tracker disabled: spot_pos forced to CENTER = N_POS/2 and hcnt = 0 at the next edge.

## Timing
- Reset values: state OFF, target OFF, xcnt 0, hcnt 0, synchroniser flops 1 (sensors idle); vis, house_lt, spot_on, mode_o all 0; spot_pos = CENTER.
- All outputs are registered (Moore, decoded from registered state); no combinational path from inputs to outputs.
- A request sampled at edge e gives BLANK after e and target state after edge e + XFADE_CYC.
- OFF request: outputs are 0 one cycle after it is sampled.
- A sensor edge on sens_n reaches s after 2 edges. A stable single sensor updates spot_pos HOLD_CYC + 2 edges after its first asserted sample.
- Reset mid-BLANK or mid-hold: immediate return to the reset values.

## Structure
- Package stage_pkg holds:
  - state enum with the codes above;
  - mode_sw bit-index constants;
  - a function computing CENTER from N_POS.
- Sub-module stage_spot_track contains the synchroniser, one-hot validity check, hold counter and position register, with inputs en and sens_n and output spot_pos.
- The top level holds the request decode, mode FSM and xcnt.

## Test plan
All scenarios use the defaults (N_POS = 4, HOLD_CYC = 3, XFADE_CYC = 4).
- Reset, then sys_en = 1 with mode_sw = 0001 at edge e: mode_o = 1 for 4 cycles, then mode_o = 2 with vis = 1, spot_on = 1 and spot_pos = 2 after edge e+4.
- In MUSIC, set mode_sw = 1000: BLANK with all outputs 0, then HOUSE with house_lt = 1. Switch to 0100 during BLANK: xcnt restarts and the final state is SPEAKER.
- In PLAY, set mode_sw = 0011 or drop sys_en: mode_o = 0 and all outputs 0 on the next cycle.
- In PLAY, hold sens_n = 1110 for 5 or more cycles: spot_pos goes 2 → 0 exactly 5 edges after the first low sample. A 2-cycle pulse produces no move.
- In SPEAKER, apply sens_n = 0110 (two sensors low): spot_pos holds. Then switch to MUSIC: spot_pos returns to 2 and spot_on = 0.
- Assert rst while in BLANK with xcnt = 2: all outputs return to reset values immediately. After release the FSM is in OFF and re-requires blanking.
